// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard controller: load-use stall, branch flush/kill and EX operand forwarding.
// Optional macro HAZARD_PERF_CNT_EN adds free-running stall_cnt/flush_cnt event counters.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 2,
    parameter int BR_STAGE   = 1,
    parameter int FW         = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  br_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [NUM_STAGES-1:0] kill_mask,
    output logic [FW-1:0]         fwd_a,
    output logic [FW-1:0]         fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [NUM_STAGES-1:0] wr_q, wr_d;
    logic [NUM_STAGES-1:0] ld_q, ld_d;
    logic [REG_AW-1:0]     rd_q [NUM_STAGES];
    logic [REG_AW-1:0]     rd_d [NUM_STAGES];
    logic [REG_AW-1:0]     rs1_q, rs1_d;
    logic [REG_AW-1:0]     rs2_q, rs2_d;
    logic                  rs1_used_q, rs1_used_d;
    logic                  rs2_used_q, rs2_used_d;
    logic                  hazard;

    // A writer blocks ID while its result becomes available later than one stage past its slot.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (v_q[k] && wr_q[k] && ((ld_q[k] ? LOAD_LAT : 1) > k + 1)) begin
                if (id_rs1_used && (id_rs1 != '0) && (rd_q[k] == id_rs1)) hazard = 1'b1;
                if (id_rs2_used && (id_rs2 != '0) && (rd_q[k] == id_rs2)) hazard = 1'b1;
            end
        end
    end

    assign stall = id_valid && !br_taken && hazard;
    assign flush = br_taken;

    always_comb begin
        kill_mask = '0;
        for (int k = 0; k < BR_STAGE; k++) kill_mask[k] = br_taken;
    end

    // Scan oldest to youngest so the youngest matching writer is the final assignment.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (v_q[0] && v_q[k] && wr_q[k]) begin
                if (rs1_used_q && (rs1_q != '0) && (rd_q[k] == rs1_q)) fwd_a = FW'(k);
                if (rs2_used_q && (rs2_q != '0) && (rd_q[k] == rs2_q)) fwd_b = FW'(k);
            end
        end
    end

    always_comb begin
        v_d  = '0;
        wr_d = '0;
        ld_d = '0;
        for (int k = 0; k < NUM_STAGES; k++) rd_d[k] = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            v_d[k]  = v_q[k-1] && !(br_taken && (k <= BR_STAGE));
            wr_d[k] = wr_q[k-1];
            ld_d[k] = ld_q[k-1];
            rd_d[k] = rd_q[k-1];
        end
        v_d[0]     = id_valid && !stall && !br_taken;
        wr_d[0]    = id_reg_write;
        ld_d[0]    = id_mem_read;
        rd_d[0]    = id_rd;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rs1_used_d = id_rs1_used;
        rs2_used_d = id_rs2_used;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q        <= '0;
            wr_q       <= '0;
            ld_q       <= '0;
            for (int k = 0; k < NUM_STAGES; k++) rd_q[k] <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_used_q <= 1'b0;
            rs2_used_q <= 1'b0;
        end else begin
            v_q        <= v_d;
            wr_q       <= wr_d;
            ld_q       <= ld_d;
            for (int k = 0; k < NUM_STAGES; k++) rd_q[k] <= rd_d[k];
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_used_q <= rs1_used_d;
            rs2_used_q <= rs2_used_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, flush};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default 3-stage instance plus a 4-stage / LOAD_LAT=3 instance.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, br_taken;

    logic       stall, flush;
    logic [2:0] kill_mask;
    logic [1:0] fwd_a, fwd_b;
    logic       stall4, flush4;
    logic [3:0] kill_mask4;
    logic [1:0] fwd_a4, fwd_b4;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt4, flush_cnt4;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       e_stall;
        logic       e_flush;
        logic [2:0] e_kill;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .br_taken(br_taken), .stall(stall), .flush(flush), .kill_mask(kill_mask),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    hazard_scoreboard #(.REG_AW(5), .NUM_STAGES(4), .LOAD_LAT(3), .BR_STAGE(1)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .br_taken(br_taken), .stall(stall4), .flush(flush4), .kill_mask(kill_mask4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
`endif
    );

    function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic br,
                                input logic e_stall, input logic e_flush, input logic [2:0] e_kill,
                                input logic [1:0] e_fa, input logic [1:0] e_fb);
        vec_t v;
        v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.wr = wr; v.ld = ld; v.br = br;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_kill = e_kill;
        v.e_fa = e_fa; v.e_fb = e_fb;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        id_valid     = v.valid;
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        id_rs1_used  = v.u1;
        id_rs2_used  = v.u2;
        id_rd        = v.rd;
        id_reg_write = v.wr;
        id_mem_read  = v.ld;
        br_taken     = v.br;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        stepCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    // One cycle: drive ID inputs, check the 3-stage outputs mid-cycle, then let the edge take them.
    task automatic runRow(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput({tag, ".stall"}, 32'(stall), 32'(v.e_stall));
        checkOutput({tag, ".flush"}, 32'(flush), 32'(v.e_flush));
        checkOutput({tag, ".kill"},  32'(kill_mask), 32'(v.e_kill));
        checkOutput({tag, ".fwd_a"}, 32'(fwd_a), 32'(v.e_fa));
        checkOutput({tag, ".fwd_b"}, 32'(fwd_b), 32'(v.e_fb));
        stepCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t nop, ld5, add6, ld7, add8;
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //        vld rs1 rs2 u1 u2 rd wr ld br | stall flush kill fa fb
        vecs.push_back(mk(1,  2,  0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0, 0)); // ld x5 (first cycle after reset)
        vecs.push_back(mk(1,  5,  1, 1, 1,  6, 1, 0, 0,  1, 0, 0, 0, 0)); // add x6,x5,x1: load-use stall
        vecs.push_back(mk(1,  5,  1, 1, 1,  6, 1, 0, 0,  0, 0, 0, 0, 0)); // add held, stall released
        vecs.push_back(mk(1,  3,  4, 1, 1,  5, 1, 0, 0,  0, 0, 0, 2, 0)); // add x5; EX add gets load via WB
        vecs.push_back(mk(1,  5,  5, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0, 0)); // sub x7,x5,x5: no stall
        vecs.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0,  0, 0, 0, 1, 1)); // sub in EX forwards both from MEM
        vecs.push_back(mk(1,  3,  4, 1, 1,  5, 1, 0, 0,  0, 0, 0, 0, 0)); // second add x5
        vecs.push_back(mk(1,  5,  5, 1, 1,  9, 1, 0, 0,  0, 0, 0, 0, 0)); // and x9,x5,x5
        vecs.push_back(mk(1,  2,  0, 1, 0,  0, 1, 1, 0,  0, 0, 0, 1, 1)); // ld x0; and in EX: youngest wins
        vecs.push_back(mk(1,  0,  0, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0)); // reader of x0 after ld x0
        vecs.push_back(mk(1,  1,  1, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0, 0)); // add x0
        vecs.push_back(mk(1,  0,  0, 1, 1, 11, 1, 0, 0,  0, 0, 0, 0, 0)); // reader of x0 after add x0
        vecs.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0)); // x0 reader in EX: no forward
        vecs.push_back(mk(1,  1,  0, 1, 0, 12, 1, 1, 0,  0, 0, 0, 0, 0)); // ld x12
        vecs.push_back(mk(1, 12,  3, 0, 1, 13, 1, 0, 0,  0, 0, 0, 0, 0)); // rs1=x12 but unused: no stall
        vecs.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0)); // unused rs1 in EX: no forward

        reset = 1'b1;
        applyStimulus(nop);
        stepCycle();
        stepCycle();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) runRow(vecs[i], $sformatf("row%0d", i));

        // Reset while a load-use hazard is pending must drop the load.
        ld5  = mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
        add6 = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(ld5);
        stepCycle();
        applyStimulus(add6);
        @(negedge clk);
        checkOutput("midreset.pre_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset.post_stall", 32'(stall), 32'd0);
        stepCycle();

        // Branch taken during a load-use stall.
        doReset();
        ld7  = mk(1, 2, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        add8 = mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        runRow(ld5,  "br.ld5");
        runRow(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0), "br.use");
        runRow(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0), "br.held");
        runRow(mk(1, 2, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 2, 0), "br.ld7");
        add8.br = 1'b1;
        applyStimulus(add8);
        @(negedge clk);
        checkOutput("br.taken.stall", 32'(stall), 32'd0);
        checkOutput("br.taken.flush", 32'(flush), 32'd1);
        checkOutput("br.taken.kill",  32'(kill_mask), 32'b001);
        checkOutput("br.taken.fwd_a", 32'(fwd_a), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("br.taken.stall_cnt", stall_cnt, 32'd1);
        checkOutput("br.taken.flush_cnt", flush_cnt, 32'd0);
`endif
        stepCycle();
        add8.br = 1'b0;
        applyStimulus(add8);
        @(negedge clk);
        checkOutput("br.after.stall", 32'(stall), 32'd0);
        checkOutput("br.after.flush", 32'(flush), 32'd0);
        checkOutput("br.after.kill",  32'(kill_mask), 32'd0);
        checkOutput("br.after.fwd_a", 32'(fwd_a), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("br.after.stall_cnt", stall_cnt, 32'd1);
        checkOutput("br.after.flush_cnt", flush_cnt, 32'd1);
`endif
        stepCycle();

        // Deeper pipe: LOAD_LAT=3 gives two bubbles, then forward from stage 3.
        doReset();
        applyStimulus(ld5);
        @(negedge clk);
        checkOutput("deep.ld.stall", 32'(stall4), 32'd0);
        stepCycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(add6);
            @(negedge clk);
            checkOutput($sformatf("deep.use%0d.stall", c), 32'(stall4), (c < 2) ? 32'd1 : 32'd0);
            stepCycle();
        end
        applyStimulus(nop);
        @(negedge clk);
        checkOutput("deep.fwd_a", 32'(fwd_a4), 32'd3);
        checkOutput("deep.fwd_b", 32'(fwd_b4), 32'd0);
        checkOutput("deep.kill",  32'(kill_mask4), 32'd0);
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
